// File: rtl/cpu_control_fsm.sv
// Multicycle fetch/decode/control sequencer for the 16-bit CPU.
// It owns the program counter and fetches instruction words over a req/ack
// handshake. Each instruction then steps through DECODE, EXEC and WB, and the
// sequencer drives the RF_ALU control vector. Write strobes fire only in WB.
module cpu_control_fsm #(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               instr_req,
    output logic [WIDTH-1:0]   instr_addr,
    input  logic               instr_ack,
    input  logic [WIDTH-1:0]   instr_rdata,
    input  logic [WIDTH-1:0]   reg_target,
    output logic [WIDTH-1:0]   pc,
    output logic               regWrite,
    output logic               shiftOrALU,
    output logic               alusrca,
    output logic               alusrcb,
    output logic               shiftType,
    output logic [WIDTH-1:0]   shiftDirection,
    output logic [REGBITS-1:0] aluControl,
    output logic [REGBITS-1:0] regAddress1,
    output logic [REGBITS-1:0] regAddress2,
    output logic [WIDTH-1:0]   immediate,
    output logic               jumpEN,
    output logic               jalEN,
    output logic               ALUselect,
    output logic [WIDTH-1:0]   RTarget,
    output logic               illegal
);

    typedef enum logic [2:0] {RESET, FETCH, DECODE, EXEC, WB} state_t;

    state_t state, next_state;

    logic [WIDTH-1:0]   ir;
    logic [3:0]         op, ext;
    logic [REGBITS-1:0] rd, rs;
    logic [7:0]         imm8;
    logic               fetch_done;

    logic               do_write, do_jump, do_jal;

    logic [REGBITS-1:0] d_alu;
    logic [WIDTH-1:0]   d_imm, d_sdir;
    logic               d_soa, d_srca, d_srcb, d_sel, d_wr, d_jump, d_jal, d_ill;

    assign op   = ir[15:12];
    assign ext  = ir[7:4];
    assign rd   = ir[8 +: REGBITS];
    assign rs   = ir[0 +: REGBITS];
    assign imm8 = ir[7:0];

    assign fetch_done = instr_req && instr_ack;
    assign instr_addr = pc;
    assign shiftType  = 1'b0;

    // The seven ALU operations share one code space in both R-form and I-form.
    function automatic logic is_alu_op(input logic [3:0] code);
        return code inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};
    endfunction

    // State register; reset parks the sequencer in FETCH at the reset vector
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= next_state;
    end

    // Next-state: wait in FETCH for the ack, then one cycle each in DECODE/EXEC/WB
    always_comb begin
        next_state = state;
        case (state)
            RESET:   next_state = FETCH;
            FETCH:   if (fetch_done) next_state = DECODE;
            DECODE:  next_state = EXEC;
            EXEC:    next_state = WB;
            WB:      next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    // Outputs: the request is gated by reset so it drops the instant reset asserts
    always_comb begin
        instr_req = (state == FETCH) && reset;
        regWrite  = (state == WB) && (do_write || do_jal);
        jumpEN    = (state == WB) && do_jump;
        jalEN     = (state == WB) && do_jal;
    end

    // Instruction decoder; undefined encodings decode as a NOP flagged illegal
    always_comb begin
        d_alu  = '0;
        d_imm  = '0;
        d_sdir = '0;
        d_soa  = 1'b0;
        d_srca = 1'b0;
        d_srcb = 1'b0;
        d_sel  = 1'b0;
        d_wr   = 1'b0;
        d_jump = 1'b0;
        d_jal  = 1'b0;
        d_ill  = 1'b0;
        if (op == 4'h0) begin
            if (is_alu_op(ext)) begin
                d_alu  = ext;
                d_soa  = 1'b1;
                d_srca = 1'b1;
                d_sel  = (ext == 4'hB);
                d_wr   = (ext != 4'hB);
            end else begin
                d_ill = 1'b1;
            end
        end else if (is_alu_op(op)) begin
            d_alu  = op;
            d_soa  = 1'b1;
            d_srca = 1'b1;
            d_srcb = 1'b1;
            d_sel  = (op == 4'hB);
            d_wr   = (op != 4'hB);
            if (op inside {4'h1, 4'h2, 4'h3})
                d_imm = {{(WIDTH-8){1'b0}}, imm8};
            else
                d_imm = {{(WIDTH-8){imm8[7]}}, imm8};
        end else if (op == 4'h8 && ext[3:1] == 3'b000) begin
            d_srca = 1'b1;
            d_srcb = 1'b1;
            d_sdir = {{(WIDTH-1){1'b0}}, ext[0]};
            d_imm  = {{(WIDTH-REGBITS){1'b0}}, rs};
            d_wr   = 1'b1;
        end else if (op == 4'h4 && ext == 4'hC) begin
            d_jal = 1'b1;
        end else if (op == 4'h4 && ext == 4'hD) begin
            d_jump = 1'b1;
        end else begin
            d_ill = 1'b1;
        end
    end

    // PC, instruction register and jump target; the PC reloads from RTarget in WB
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_PC;
            ir      <= '0;
            RTarget <= '0;
        end else begin
            if (state == FETCH && fetch_done) begin
                ir <= instr_rdata;
                pc <= pc + WIDTH'(1);
            end
            if (state == EXEC && (do_jump || do_jal))
                RTarget <= reg_target;
            if (state == WB && (do_jump || do_jal))
                pc <= RTarget;
        end
    end

    // Control vector registers, loaded once in DECODE and held until the next one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aluControl     <= '0;
            regAddress1    <= '0;
            regAddress2    <= '0;
            immediate      <= '0;
            shiftDirection <= '0;
            shiftOrALU     <= 1'b0;
            alusrca        <= 1'b0;
            alusrcb        <= 1'b0;
            ALUselect      <= 1'b0;
            do_write       <= 1'b0;
            do_jump        <= 1'b0;
            do_jal         <= 1'b0;
            illegal        <= 1'b0;
        end else if (state == DECODE) begin
            aluControl     <= d_alu;
            regAddress1    <= rd;
            regAddress2    <= rs;
            immediate      <= d_imm;
            shiftDirection <= d_sdir;
            shiftOrALU     <= d_soa;
            alusrca        <= d_srca;
            alusrcb        <= d_srcb;
            ALUselect      <= d_sel;
            do_write       <= d_wr;
            do_jump        <= d_jump;
            do_jal         <= d_jal;
            if (d_ill) illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: a table of instructions with their expected WB
// control vectors, pushed to a scoreboard on the ack and popped at WB.
module tb_cpu_control_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_req, instr_ack;
    logic [15:0] instr_addr, instr_rdata, reg_target, pc;
    logic        regWrite, shiftOrALU, alusrca, alusrcb, shiftType;
    logic [15:0] shiftDirection, immediate, RTarget;
    logic [3:0]  aluControl, regAddress1, regAddress2;
    logic        jumpEN, jalEN, ALUselect, illegal;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] tgt;
        logic        spur;
        logic        rw, soa, srca, srcb;
        logic [15:0] sdir;
        logic [3:0]  alu, a1, a2;
        logic [15:0] imm;
        logic        je, jal, sel, ill;
        logic [15:0] next_pc;
    } vec_t;

    vec_t        vecs[16];
    vec_t        sbq[$];
    logic [15:0] pc_model;
    int          n_checks = 0;
    int          n_pass = 0;

    cpu_control_fsm #(.WIDTH(16), .REGBITS(4), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_ack(instr_ack), .instr_rdata(instr_rdata),
        .reg_target(reg_target), .pc(pc),
        .regWrite(regWrite), .shiftOrALU(shiftOrALU),
        .alusrca(alusrca), .alusrcb(alusrcb),
        .shiftType(shiftType), .shiftDirection(shiftDirection),
        .aluControl(aluControl), .regAddress1(regAddress1),
        .regAddress2(regAddress2), .immediate(immediate),
        .jumpEN(jumpEN), .jalEN(jalEN), .ALUselect(ALUselect),
        .RTarget(RTarget), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Safety net so a wedged DUT still ends the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic [15:0] instr, input logic [15:0] tgt,
                                input logic spur, input logic rw, input logic soa,
                                input logic srca, input logic srcb, input logic [15:0] sdir,
                                input logic [3:0] alu, input logic [3:0] a1, input logic [3:0] a2,
                                input logic [15:0] imm, input logic je, input logic jal,
                                input logic sel, input logic ill, input logic [15:0] next_pc);
        vec_t v;
        v.instr = instr; v.tgt = tgt; v.spur = spur;
        v.rw = rw; v.soa = soa; v.srca = srca; v.srcb = srcb; v.sdir = sdir;
        v.alu = alu; v.a1 = a1; v.a2 = a2; v.imm = imm;
        v.je = je; v.jal = jal; v.sel = sel; v.ill = ill; v.next_pc = next_pc;
        return v;
    endfunction

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // Waits for the fetch, acks it in the same cycle and walks through DECODE/EXEC
    task automatic applyStimulus(input vec_t v);
        int wait_cyc = 0;
        while (!instr_req && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        check_val("fetch req", instr_req, 1);
        if (!instr_req) return;
        check_val("fetch addr", instr_addr, pc_model);
        instr_ack   = 1'b1;
        instr_rdata = v.instr;
        reg_target  = v.tgt;
        sbq.push_back(v);
        @(negedge clk);
        instr_ack   = 1'b0;
        instr_rdata = 16'h0000;
        check_val("req drop", instr_req, 0);
        @(negedge clk);
        check_val("exec strobes", {regWrite, jumpEN, jalEN}, 0);
        if (v.spur) begin
            instr_ack   = 1'b1;
            instr_rdata = 16'hF000;
        end
        @(negedge clk);
        instr_ack   = 1'b0;
        instr_rdata = 16'h0000;
    endtask

    // Called in WB: pops the expected vector, then checks the strobe drop
    task automatic checkOutput();
        vec_t        e;
        logic [15:0] wb_pc;
        if (sbq.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = sbq.pop_front();
        wb_pc = pc_model + 16'd1;
        check_val("regWrite", regWrite, e.rw);
        check_val("shiftOrALU", shiftOrALU, e.soa);
        check_val("alusrca", alusrca, e.srca);
        check_val("alusrcb", alusrcb, e.srcb);
        check_val("shiftType", shiftType, 0);
        check_val("shiftDirection", shiftDirection, e.sdir);
        check_val("aluControl", aluControl, e.alu);
        check_val("regAddress1", regAddress1, e.a1);
        check_val("regAddress2", regAddress2, e.a2);
        check_val("immediate", immediate, e.imm);
        check_val("jumpEN", jumpEN, e.je);
        check_val("jalEN", jalEN, e.jal);
        check_val("ALUselect", ALUselect, e.sel);
        check_val("illegal", illegal, e.ill);
        check_val("pc at wb", pc, wb_pc);
        if (e.je || e.jal) check_val("RTarget", RTarget, e.tgt);
        @(negedge clk);
        check_val("strobes after wb", {regWrite, jumpEN, jalEN}, 0);
        check_val("req reassert", instr_req, 1);
        pc_model = e.next_pc;
    endtask

    initial begin
        //              instr     tgt       sp rw so sa sb sdir      alu   a1    a2    imm       je jl sl il next
        vecs[0]  = mk(16'h0112, 16'h0000, 1, 1, 1, 1, 0, 16'h0000, 4'h1, 4'h1, 4'h2, 16'h0000, 0, 0, 0, 0, 16'h0001);
        vecs[1]  = mk(16'h53F0, 16'h0000, 0, 1, 1, 1, 1, 16'h0000, 4'h5, 4'h3, 4'h0, 16'hFFF0, 0, 0, 0, 0, 16'h0002);
        vecs[2]  = mk(16'h13F0, 16'h0000, 0, 1, 1, 1, 1, 16'h0000, 4'h1, 4'h3, 4'h0, 16'h00F0, 0, 0, 0, 0, 16'h0003);
        vecs[3]  = mk(16'hB3F0, 16'h0000, 0, 0, 1, 1, 1, 16'h0000, 4'hB, 4'h3, 4'h0, 16'hFFF0, 0, 0, 1, 0, 16'h0004);
        vecs[4]  = mk(16'h04D5, 16'h0000, 0, 1, 1, 1, 0, 16'h0000, 4'hD, 4'h4, 4'h5, 16'h0000, 0, 0, 0, 0, 16'h0005);
        vecs[5]  = mk(16'h0697, 16'h0000, 0, 1, 1, 1, 0, 16'h0000, 4'h9, 4'h6, 4'h7, 16'h0000, 0, 0, 0, 0, 16'h0006);
        vecs[6]  = mk(16'h01B2, 16'h0000, 0, 0, 1, 1, 0, 16'h0000, 4'hB, 4'h1, 4'h2, 16'h0000, 0, 0, 1, 0, 16'h0007);
        vecs[7]  = mk(16'h4AC5, 16'h0040, 0, 1, 0, 0, 0, 16'h0000, 4'h0, 4'hA, 4'h5, 16'h0000, 0, 1, 0, 0, 16'h0040);
        vecs[8]  = mk(16'h8213, 16'h0000, 0, 1, 0, 1, 1, 16'h0001, 4'h0, 4'h2, 4'h3, 16'h0003, 0, 0, 0, 0, 16'h0041);
        vecs[9]  = mk(16'h8203, 16'h0000, 0, 1, 0, 1, 1, 16'h0000, 4'h0, 4'h2, 4'h3, 16'h0003, 0, 0, 0, 0, 16'h0042);
        vecs[10] = mk(16'h40D9, 16'h0100, 0, 0, 0, 0, 0, 16'h0000, 4'h0, 4'h0, 4'h9, 16'h0000, 1, 0, 0, 0, 16'h0100);
        vecs[11] = mk(16'hF000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 4'h0, 4'h0, 4'h0, 16'h0000, 0, 0, 0, 1, 16'h0101);
        vecs[12] = mk(16'h2555, 16'h0000, 0, 1, 1, 1, 1, 16'h0000, 4'h2, 4'h5, 4'h5, 16'h0055, 0, 0, 0, 1, 16'h0102);
        vecs[13] = mk(16'h40D9, 16'hFFFF, 0, 0, 0, 0, 0, 16'h0000, 4'h0, 4'h0, 4'h9, 16'h0000, 1, 0, 0, 1, 16'hFFFF);
        vecs[14] = mk(16'h0112, 16'h0000, 0, 1, 1, 1, 0, 16'h0000, 4'h1, 4'h1, 4'h2, 16'h0000, 0, 0, 0, 1, 16'h0000);
        vecs[15] = mk(16'h517F, 16'h0000, 0, 1, 1, 1, 1, 16'h0000, 4'h5, 4'h1, 4'hF, 16'h007F, 0, 0, 0, 1, 16'h0001);

        reset       = 1'b0;
        instr_ack   = 1'b0;
        instr_rdata = 16'h0000;
        reg_target  = 16'h0000;
        pc_model    = 16'h0000;

        // Reset held with a stray ack pulsing: nothing may start
        repeat (2) @(negedge clk);
        instr_ack   = 1'b1;
        instr_rdata = 16'h0112;
        @(negedge clk);
        check_val("rst req", instr_req, 0);
        check_val("rst pc", pc, 16'h0000);
        check_val("rst strobes", {regWrite, jumpEN, jalEN, ALUselect}, 0);
        check_val("rst illegal", illegal, 0);
        check_val("rst immediate", immediate, 16'h0000);
        check_val("rst RTarget", RTarget, 16'h0000);
        check_val("rst addresses", {regAddress1, regAddress2}, 0);
        check_val("rst shiftDirection", shiftDirection, 16'h0000);
        instr_ack   = 1'b0;
        instr_rdata = 16'h0000;
        reset       = 1'b1;
        @(negedge clk);
        check_val("post-rst req", instr_req, 1);
        check_val("post-rst addr", instr_addr, 16'h0000);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
            checkOutput();
        end

        // Stall the fetch five cycles, then reset asynchronously mid-cycle
        for (int i = 0; i < 5; i++) begin
            check_val("stall req", instr_req, 1);
            check_val("stall addr", instr_addr, pc_model);
            @(negedge clk);
        end
        #2;
        reset = 1'b0;
        #1;
        check_val("async req drop", instr_req, 0);
        check_val("async pc", pc, 16'h0000);
        check_val("async illegal", illegal, 0);
        check_val("async regAddress1", regAddress1, 4'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("final req", instr_req, 1);
        check_val("final addr", instr_addr, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
- Multicycle fetch/decode/control sequencer for the 16-bit CPU. It sits directly upstream of the RF_ALU datapath.
- Owns the program counter and fetches instruction words over a req/ack handshake, then decodes each into the RF_ALU control vector.
- Sequences each instruction through DECODE, EXEC and WB states.

Parameters:
WIDTH, 16, datapath/instruction width
REGBITS, 4, register address width
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
instr_req  out  1  fetch request, held until ack
instr_addr  out  WIDTH  fetch address (= pc)
instr_ack  in  1  fetch data valid this cycle
instr_rdata  in  WIDTH  fetched instruction word
reg_target  in  WIDTH  Rsrc register value from RF_ALU, used as jump target
pc  out  WIDTH  current PC; drives RF_ALU pc
regWrite  out  1  RF write enable
shiftOrALU  out  1  1 = ALU result, 0 = shifter result
alusrca  out  1  1 = RF port A operand
alusrcb  out  1  1 = immediate, 0 = RF port B
shiftType  out  1  0 = logical shift
shiftDirection  out  WIDTH  16'h0001 = left, 16'h0000 = right
aluControl  out  REGBITS  ALU operation code
regAddress1  out  REGBITS  Rdest / operand A
regAddress2  out  REGBITS  Rsrc / operand B
immediate  out  WIDTH  extended immediate
jumpEN  out  1  load PC from RTarget
jalEN  out  1  write link (pc) into Rdest
ALUselect  out  1  1 = flags-only op (CMP)
RTarget  out  WIDTH  jump target to RF_ALU
illegal  out  1  sticky: undefined opcode seen

Behaviour:
- Encoding: [15:12] op, [11:8] Rdest, [7:4] ext, [3:0] Rsrc; imm8 = [7:0].
- op 0000 is R-type, with ext 0001 AND, 0010 OR, 0011 XOR, 0101 ADD, 1001 SUB, 1011 CMP, 1101 MOV; aluControl = ext.
- op 0001/0010/0011/0101/1001/1011/1101 is the I-form of the same op; aluControl = op.
  - Immediate is zero-extended for 0001/0010/0011, sign-extended otherwise.
  - alusrcb = 1.
- op 1000 with ext[3:1] = 000 is LSHI.
  - ext[0] is direction (1 = left); amount is Rsrc field, immediate = {12'b0, Rsrc}.
  - shiftOrALU = 0, alusrcb = 1.
- op 0100 with ext 1100 is JAL; ext 1101 is JUMP. Target is reg_target.
- Any other encoding: illegal <= 1 (sticky until reset); treated as NOP.
- States are RESET, FETCH, DECODE, EXEC, WB.
- Reset (reset = 0, asynchronous):
  - State goes to FETCH and pc = RESET_PC.
  - instr_req = 0 and illegal = 0.
  - All control outputs are 0: regWrite = jumpEN = jalEN = ALUselect = 0, immediate = 0, addresses = 0, shiftDirection = 0, RTarget = 0.
  - Reset mid-fetch drops instr_req the same instant; an in-flight ack after release is ignored unless instr_req = 1.
- FETCH:
  - instr_req = 1 and instr_addr = pc. instr_ack with instr_req = 0 is ignored.
  - On the instr_ack cycle: IR <= instr_rdata, pc <= pc + 1 (wraps FFFF to 0000), instr_req deasserts next cycle, go to DECODE.
- DECODE (1 cycle): register regAddress1/2, immediate, aluControl, mux selects and ALUselect from IR. regWrite = 0.
- EXEC (1 cycle): controls held stable; RTarget <= reg_target for jumps. regWrite = 0.
- WB (1 cycle):
  - regWrite = 1 for ALU/shift ops except CMP/CMPI.
  - JUMP: jumpEN = 1 and pc <= RTarget.
  - JAL: jalEN = 1, regWrite = 1, and pc <= RTarget. The link value is the pc before load, i.e. the fetch address + 1.
  - NOP/illegal: no strobes.
  - Next state is FETCH.
- Strobes (regWrite, jumpEN, jalEN) are high exactly one cycle, in WB only.
- Instruction latency is ack cycle + 3 cycles. Minimum 4 cycles per instruction with same-cycle ack.

Test Plan:
- Hold reset = 0 with instr_ack pulsed -> instr_req = 0, pc = 0000, all strobes 0, illegal = 0. After release: FETCH with instr_addr = 0000.
- Fetch 16'h0112 (AND R1,R2) with immediate ack -> at WB: regWrite = 1 for one cycle, aluControl = 0001, regAddress1 = 1, regAddress2 = 2, alusrcb = 0, shiftOrALU = 1. pc = 0001, and instr_req re-asserts 4 cycles after ack.
- Fetch 16'h53F0 (ADDI R3,#-16) -> immediate = FFF0, alusrcb = 1, aluControl = 0101. Then 16'h13F0 (ANDI) -> immediate = 00F0. Then 16'hB3F0 (CMPI) -> ALUselect = 1 and regWrite never asserts.
- Fetch 16'h4AC5 (JAL R10,R5) at pc 0007 with reg_target = 0040 -> WB has jalEN = 1, regWrite = 1, regAddress1 = A, jumpEN = 0. Next instr_addr = 0040.
- Fetch 16'h8213 (LSHI R2, left, 3) -> shiftOrALU = 0, shiftDirection = 0001, immediate = 0003. Then 16'hF000 -> illegal = 1, no strobes, pc still advances, and illegal stays set.
- Hold instr_ack low 5 cycles, then assert reset = 0 mid-FETCH -> instr_req stays high while waiting and drops asynchronously on reset; pc returns to 0000.
